// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Start/done handshake; the last result is held until the next conversion completes.

module bin2bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);
    // Values 5..9 become 8..12 so the following shift carries into the next digit.
    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state, state_next;
    logic [WIDTH-1:0]      shreg, shreg_next;
    logic [4*DIGITS-1:0]   scratch, adj, scratch_next;
    logic                  ovf_acc, ovf_next, carry_out;
    logic [CW-1:0]         count;
    logic                  accept, last;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bin2bcd_digit_adj u_adj (
            .digit    (scratch[4*d +: 4]),
            .adjusted (adj[4*d +: 4])
        );
    end

    // The bit leaving the top digit is lost range: remember it as overflow.
    assign {carry_out, scratch_next, shreg_next} = {adj, shreg, 1'b0};
    assign ovf_next = ovf_acc | carry_out;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (count == CW'(1));
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last)  state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            scratch  <= '0;
            ovf_acc  <= 1'b0;
            count    <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            shreg   <= bin;
            scratch <= '0;
            ovf_acc <= 1'b0;
            count   <= CW'(WIDTH);
        end else if (state == SHIFT) begin
            shreg   <= shreg_next;
            scratch <= scratch_next;
            ovf_acc <= ovf_next;
            count   <= count - CW'(1);
            if (last) begin
                bcd      <= scratch_next;
                overflow <= ovf_next;
            end
        end
    end
endmodule
